sub_vector_driver: RTL and testbench
====================================

# sub_vector_driver

- Synthesizable stimulus/checker that drives the operand ports of a generated `sub` kernel (`a`, `b`) and checks its result port (`y`) against an internal reference model, (a − b) mod 2^WIDTH.
- Sits opposite the DUT for on-board self-test of compiled arithmetic kernels.
- Steps through a fixed directed vector table, optionally followed by pseudo-random vectors, and reports pass, or the first failing vector.

## Interface
- WIDTH, 8, operand/result width
- LATENCY, 0, cycles from operands presented to `dut_y` valid (0 = combinational DUT)
- NUM_RANDOM, 8, pseudo-random vectors appended when the LFSR feature is compiled in

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE or DONE
- dut_a  out  WIDTH  operand a to DUT, registered
- dut_b  out  WIDTH  operand b to DUT, registered
- dut_y  in  WIDTH  DUT result
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  all vectors matched; valid when done
- fail  out  1  mismatch detected; valid when done
- fail_index  out  8  index of first failing vector
- observed  out  WIDTH  `dut_y` captured at the failing compare

## Operation
- States: IDLE, DRIVE, DONE.
- Reset: state IDLE; all outputs 0; vector index 0; compare counter 0; LFSR reseeded to 0x3EAD.
- IDLE or DONE, start=1:
  - load vector 0 into `dut_a`/`dut_b`
  - clear done, pass, fail, fail_index, observed
  - counter = 0, busy = 1, go to DRIVE
- DRIVE, each edge:
  - If counter == LATENCY, compare `dut_y` with the expected value.
  - Match, more vectors remain: load the next vector, counter = 0.
  - Match on the last vector: go to DONE with done=1, pass=1, busy=0.
  - Mismatch: go to DONE with done=1, fail=1, busy=0, fail_index = current index, observed = `dut_y`.
  - Otherwise (counter < LATENCY): counter++.
- Operands are held stable for the whole LATENCY+1 window.
- In DONE, `dut_a`/`dut_b` hold the last vector.
- start while busy is ignored.
- Directed table, 5 entries. Values are integers truncated to WIDTH; expected = (a − b) mod 2^WIDTH:
  - idx 0: a=1, b=−3 → 4
  - idx 1: a=0, b=0 → 0
  - idx 2: a=0, b=1 → 0xFF (wrap)
  - idx 3: a=0x80, b=1 → 0x7F
  - idx 4: a=0x7F, b=0xFF → 0x80
- Expected values are computed by a WIDTH-bit subtractor with no carry-out; the table stores no expected values.

## Timing
- Start edge to done edge: N × (LATENCY+1) cycles, where N is the total vector count.
  - A mismatch on vector k ends the run k×(LATENCY+1)+LATENCY+1 cycles after the start edge.
- Reset has priority over start and over a compare in the same cycle.
- Reset mid-run: IDLE and all outputs 0 on that edge. The next start reruns from vector 0 with a reseeded LFSR.
- start and reset asserted together: reset wins, and start is not remembered.

## Configuration
- SUB_VECTOR_DRIVER_LFSR_EN defined:
  - After the 5 directed vectors, run NUM_RANDOM vectors from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0x3EAD).
  - For each random vector, a = lfsr[WIDTH-1:0] and b = lfsr[15:8] (for WIDTH=8); the LFSR steps once per vector load.
  - N = 5 + NUM_RANDOM.
- Undefined:
  - N = 5, NUM_RANDOM is ignored, and no LFSR logic is instantiated.

## Structure
- Package `sub_vector_driver_pkg` holds:
  - state enum
  - NUM_DIRECTED = 5
  - directed operand table as integer constants
  - LFSR seed and tap constants
- One sub-module, `lfsr16`, with ports clock, reset, step, value. It is instantiated only under SUB_VECTOR_DRIVER_LFSR_EN.
- Top level holds the FSM, compare counter, vector index, reference subtractor and result registers.

## Test plan
- Correct combinational DUT, LATENCY=0, macro off, start pulse → done=pass=1 exactly 5 cycles after the start edge; fail=0.
- Correct DUT with 2 register stages, LATENCY=2 → done=pass=1 after 15 cycles; `dut_a`/`dut_b` stable for 3 cycles per vector.
- Faulty DUT y=a+b → fail=1 after 1 cycle; fail_index=0; observed=0xFE; pass=0.
- DUT saturating at 0 → fail_index=2, observed=0x00, after 3 cycles.
- Reset asserted while on vector 2 → all outputs 0 on the next edge; a subsequent start presents a=1, b=0xFD first, and the run passes.
- Macro on, NUM_RANDOM=8 → pass after 13 cycles; the first random vector's expected value is checked against the bench model, and a saturating DUT is caught.

Source files
------------

// File: rtl/sub_vector_driver_pkg.sv
// sub_vector_driver_pkg: states, directed operand table and LFSR constants shared by the driver.
package sub_vector_driver_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam int NUM_DIRECTED = 5;

    // Operands are plain integers; the driver truncates them to its WIDTH.
    localparam integer DIR_A [NUM_DIRECTED] = '{1, 0, 0, 'h80, 'h7F};
    localparam integer DIR_B [NUM_DIRECTED] = '{-3, 0, 1, 1, 'hFF};

    localparam logic [15:0] LFSR_SEED = 16'h3EAD;
    // Fibonacci taps 16,14,13,11 as a mask over value[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sub_vector_driver_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, reseeded on reset, advancing one step per step pulse.
module lfsr16
    import sub_vector_driver_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clock) begin
        if (reset) value <= LFSR_SEED;
        else if (step) value <= {value[14:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/sub_vector_driver.sv
// sub_vector_driver: drives a/b into a sub kernel and checks y against (a - b) mod 2^WIDTH.
// Define SUB_VECTOR_DRIVER_LFSR_EN to append NUM_RANDOM LFSR vectors after the directed table.
module sub_vector_driver
    import sub_vector_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 0,
    parameter int NUM_RANDOM = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [7:0]       fail_index,
    output logic [WIDTH-1:0] observed
);

`ifdef SUB_VECTOR_DRIVER_LFSR_EN
    localparam int NUM_VEC = NUM_DIRECTED + NUM_RANDOM;
`else
    localparam int NUM_VEC = NUM_DIRECTED;
`endif
    localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;

    if (NUM_RANDOM < 0 || NUM_DIRECTED + NUM_RANDOM > 256) begin : g_bad_num_random
        $error("NUM_RANDOM must keep the vector count within an 8-bit index");
    end

    state_t           state, state_next;
    logic [7:0]       idx, load_idx;
    logic [2:0]       sel;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] expected, next_a, next_b;
    logic             compare, match, last;

    assign expected = dut_a - dut_b;
    assign compare  = (state == DRIVE) && (cnt == CW'(LATENCY));
    assign match    = dut_y == expected;
    assign last     = idx == 8'(NUM_VEC - 1);
    assign load_idx = (state == DRIVE) ? idx + 8'd1 : 8'd0;
    assign sel      = load_idx < 8'(NUM_DIRECTED) ? load_idx[2:0] : 3'd0;

`ifdef SUB_VECTOR_DRIVER_LFSR_EN
    logic [15:0] lfsr;
    logic        random, load;

    assign random = load_idx >= 8'(NUM_DIRECTED);
    // The LFSR only advances when a random vector is actually taken into dut_a/dut_b.
    assign load   = (state == DRIVE) ? compare && match && !last : start;
    assign next_a = random ? lfsr[WIDTH-1:0] : WIDTH'(DIR_A[sel]);
    assign next_b = random ? lfsr[15 -: WIDTH] : WIDTH'(DIR_B[sel]);

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (load && random),
        .value (lfsr)
    );
`else
    assign next_a = WIDTH'(DIR_A[sel]);
    assign next_b = WIDTH'(DIR_B[sel]);
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = (state != DRIVE) ? (start ? DRIVE : state)
                   : (compare && (!match || last)) ? DONE : DRIVE;
    end

    always_comb begin
        busy = state == DRIVE;
        done = state == DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dut_a      <= '0;
            dut_b      <= '0;
            idx        <= '0;
            cnt        <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_index <= '0;
            observed   <= '0;
        end else if (state != DRIVE) begin
            if (start) begin
                dut_a      <= next_a;
                dut_b      <= next_b;
                idx        <= '0;
                cnt        <= '0;
                pass       <= 1'b0;
                fail       <= 1'b0;
                fail_index <= '0;
                observed   <= '0;
            end
        end else if (compare) begin
            if (!match) begin
                fail       <= 1'b1;
                fail_index <= idx;
                observed   <= dut_y;
            end else if (last) begin
                pass <= 1'b1;
            end else begin
                dut_a <= next_a;
                dut_b <= next_b;
                idx   <= idx + 8'd1;
                cnt   <= '0;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub_vector_driver.sv
// tb_sub_vector_driver: directed checks of the driver against good, adding and saturating kernels.
module tb_sub_vector_driver;

`ifdef SUB_VECTOR_DRIVER_LFSR_EN
    localparam int NV = 13;
`else
    localparam int NV = 5;
`endif

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [7:0] a, b, y, a2, b2, y2, s1, s2, fidx, obs, fidx2, obs2;
    logic busy, done, pass, fail, busy2, done2, pass2, fail2;
    logic [1:0] mode = 2'd0;
    logic signed [8:0] sd;
    logic [7:0] ta [5] = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tbv [5] = '{8'hFD, 8'h00, 8'h01, 8'h01, 8'hFF};
    int n = 0, nfail = 0, cyc = 0;

    always #5 clock = ~clock;

    // Kernel models: 0 correct, 1 adds instead, 2 signed difference clamped at zero.
    assign sd = $signed({a[7], a}) - $signed({b[7], b});
    assign y  = (mode == 2'd0) ? 8'(a - b) : (mode == 2'd1) ? 8'(a + b) : (sd < 0 ? 8'h00 : sd[7:0]);

    always_ff @(posedge clock) begin
        s1 <= a2 - b2;
        s2 <= s1;
    end
    assign y2 = s2;

    sub_vector_driver #(.WIDTH(8), .LATENCY(0), .NUM_RANDOM(8)) u_dut (
        .clock(clock), .reset(reset), .start(start), .dut_a(a), .dut_b(b), .dut_y(y),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_index(fidx), .observed(obs)
    );

    sub_vector_driver #(.WIDTH(8), .LATENCY(2), .NUM_RANDOM(8)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2), .dut_a(a2), .dut_b(b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .fail_index(fidx2), .observed(obs2)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
        n++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Advance until done (bounded), checking the operands of each directed vector on the way.
    task automatic run(input int off, input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            if (cycles + off < 5) begin
                check("vec_a", a, ta[cycles + off]);
                check("vec_b", b, tbv[cycles + off]);
            end
`ifdef SUB_VECTOR_DRIVER_LFSR_EN
            if (cycles + off == 5 && mode == 2'd0) begin
                check("rand0_a", a, 8'hAD);
                check("rand0_b", b, 8'h3E);
                check("rand0_y", y, 8'h6F);
            end
`endif
            tick;
            cycles++;
        end
    endtask

    initial begin
        repeat (2) tick;
        check("rst_flags", {4'd0, busy, done, pass, fail}, 8'h0);
        check("rst_a", a, 8'h00);
        check("rst_b", b, 8'h00);
        check("rst_fidx", fidx, 8'h00);
        check("rst_obs", obs, 8'h00);
        check("rst_flags2", {4'd0, busy2, done2, pass2, fail2}, 8'h0);
        reset = 1'b0;
        tick;

        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_flags", {4'd0, busy, done, pass, fail}, 8'b1000);
        run(0, 60, cyc);
        check("pass_cycles", 8'(cyc), 8'(NV));
        check("pass_flags", {4'd0, busy, done, pass, fail}, 8'b0110);
        repeat (3) tick;
        check("hold_flags", {4'd0, busy, done, pass, fail}, 8'b0110);
`ifndef SUB_VECTOR_DRIVER_LFSR_EN
        check("hold_a", a, 8'h7F);
        check("hold_b", b, 8'hFF);
`endif

        mode = 2'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        run(0, 60, cyc);
        check("add_cycles", 8'(cyc), 8'd1);
        check("add_flags", {4'd0, busy, done, pass, fail}, 8'b0101);
        check("add_fidx", fidx, 8'd0);
        check("add_obs", obs, 8'hFE);

        mode = 2'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        run(0, 60, cyc);
        check("sat_cycles", 8'(cyc), 8'd3);
        check("sat_flags", {4'd0, busy, done, pass, fail}, 8'b0101);
        check("sat_fidx", fidx, 8'd2);
        check("sat_obs", obs, 8'h00);

        mode = 2'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2) tick;
        check("mid_a", a, 8'h00);
        check("mid_b", b, 8'h01);
        reset = 1'b1;
        tick;
        check("midrst_flags", {4'd0, busy, done, pass, fail}, 8'h0);
        check("midrst_a", a, 8'h00);
        check("midrst_b", b, 8'h00);
        start = 1'b1;
        tick;
        start = 1'b0;
        reset = 1'b0;
        tick;
        check("rst_start_forgot", {4'd0, busy, done, pass, fail}, 8'h0);
        start = 1'b1;
        tick;
        start = 1'b0;
        run(0, 60, cyc);
        check("rerun_cycles", 8'(cyc), 8'(NV));
        check("rerun_flags", {4'd0, busy, done, pass, fail}, 8'b0110);

        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        run(2, 60, cyc);
        check("busy_start_cycles", 8'(cyc + 2), 8'(NV));
        check("busy_start_flags", {4'd0, busy, done, pass, fail}, 8'b0110);

        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            if (cyc / 3 < 5) begin
                check("lat2_a", a2, ta[cyc / 3]);
                check("lat2_b", b2, tbv[cyc / 3]);
            end
            tick;
            cyc++;
        end
        check("lat2_cycles", 8'(cyc), 8'(3 * NV));
        check("lat2_flags", {4'd0, busy2, done2, pass2, fail2}, 8'b0110);

        $display("End of test - %0d assertions evaluated, %0d failures", n, nfail);
        $finish;
    end

endmodule
